// File: rtl/ram_arbiter.sv
// Two-port arbiter and access sequencer for the RAM256x8 data memory.
// Port 0 is the CPU data port, port 1 the loader/debug port. One command is
// accepted per clock; each accepted command gets a one-cycle RAM access the
// next cycle, and reads return data one cycle after that.
module ram_arbiter #(
  parameter int unsigned PRIO_MODE  = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       we0,
  input  logic [7:0] addr0,
  input  logic [7:0] wdata0,
  output logic       gnt0,
  output logic       rvalid0,
  output logic [7:0] rdata0,
  input  logic       req1,
  input  logic       we1,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata1,
  output logic       gnt1,
  output logic       rvalid1,
  output logic [7:0] rdata1,
  output logic [7:0] ram_address,
  output logic [7:0] ram_data_in,
  output logic       n_cs,
  output logic       n_oe,
  output logic       n_we,
  input  logic [7:0] ram_data_out,
  output logic       busy
);

  localparam logic [3:0] LpStarveMax = 4'(STARVE_MAX);

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  state_e     r_state;
  logic       r_we;
  logic       r_port;
  logic [3:0] r_starve;
  logic       r_last;

  logic       w_pick1;
  logic       w_xfer;
  logic       w_we;
  logic [7:0] w_addr;
  logic [7:0] w_wdata;

  // Arbitration: a lone requester wins; ties go by round-robin or by fixed
  // priority to port 0 unless port 1 has been refused STARVE_MAX times.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    w_pick1 = 1'b0;
    if (req0 && req1) begin
      if (PRIO_MODE == 0) w_pick1 = (r_last == 1'b0);
      else                w_pick1 = (r_starve == LpStarveMax);
      gnt1 = w_pick1;
      gnt0 = ~w_pick1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  // Select the winning port's command for the access stage.
  always_comb begin
    w_xfer  = gnt0 | gnt1;
    w_we    = gnt1 ? we1    : we0;
    w_addr  = gnt1 ? addr1  : addr0;
    w_wdata = gnt1 ? wdata1 : wdata0;
  end

  // Starvation counter for port 1 and last-winner memory for round-robin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve <= 4'd0;
      r_last   <= 1'b1;
    end else begin
      if (req1 && !gnt1) begin
        if (r_starve != LpStarveMax) r_starve <= r_starve + 4'd1;
      end else begin
        r_starve <= 4'd0;
      end
      if (gnt0)      r_last <= 1'b0;
      else if (gnt1) r_last <= 1'b1;
    end
  end

  // Access-cycle FSM with registered RAM strobes, address and write data.
  // Address and data hold their last values while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      n_cs        <= 1'b1;
      n_oe        <= 1'b1;
      n_we        <= 1'b1;
      busy        <= 1'b0;
      ram_address <= 8'h00;
      ram_data_in <= 8'h00;
      r_we        <= 1'b0;
      r_port      <= 1'b0;
    end else begin
      r_state <= w_xfer ? StAcc : StIdle;
      n_cs    <= ~w_xfer;
      n_oe    <= ~(w_xfer & ~w_we);
      n_we    <= ~(w_xfer & w_we);
      busy    <= w_xfer;
      if (w_xfer) begin
        ram_address <= w_addr;
        ram_data_in <= w_wdata;
        r_we        <= w_we;
        r_port      <= gnt1;
      end
    end
  end

  // Capture read data at the end of a read access and pulse the owner's rvalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= 8'h00;
      rdata1  <= 8'h00;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if (r_state == StAcc && !r_we) begin
        if (r_port) begin
          rvalid1 <= 1'b1;
          rdata1  <= ram_data_out;
        end else begin
          rvalid0 <= 1'b1;
          rdata0  <= ram_data_out;
        end
      end
    end
  end

endmodule
